// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid_pkg: stage-register state encodings and control offsets  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pipe_stage_skid_pkg;

    localparam logic [1:0] PS_EMPTY = 2'd0;
    localparam logic [1:0] PS_ONE   = 2'd1;
    localparam logic [1:0] PS_TWO   = 2'd2;

    // Bit offsets of the per-stage control fields inside the ctrl payload
    localparam int CTRL_RF_WE   = 0;
    localparam int CTRL_DRAM_WE = 1;
    localparam int CTRL_WD_SEL  = 2;
    localparam int CTRL_ALU_OP  = 4;

endpackage : pipe_stage_skid_pkg
`default_nettype wire

// File: rtl/pipe_en_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_en_reg: W-bit register, async active-low reset, enable, sync clear  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_en_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load so a kill in the same cycle never lets new data in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_en_reg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid: valid/ready pipeline stage with flush, bubble, skid     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              w_main_en;
    logic              w_main_ctrl_clr;
    logic [DATA_W-1:0] w_main_data_d;
    logic [CTRL_W-1:0] w_main_ctrl_d;

    // Data is never cleared on a bubble; only ctrl is forced to zero
    pipe_en_reg #(.W(DATA_W)) u_main_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_main_en),
        .clr   (1'b0),
        .d     (w_main_data_d),
        .q     (out_data)
    );

    pipe_en_reg #(.W(CTRL_W)) u_main_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_main_en),
        .clr   (w_main_ctrl_clr),
        .d     (w_main_ctrl_d),
        .q     (out_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]        r_state;
            logic [1:0]        w_state_next;
            logic              r_in_ready;
            logic              w_accept;
            logic              w_fire;
            logic              w_main_sel_skid;
            logic              w_skid_en;
            logic              w_skid_clr;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;

            assign w_accept = in_valid & r_in_ready & ~flush;
            assign w_fire   = (r_state != PS_EMPTY) & out_ready;

            // in_ready is precomputed from the next state so it leaves as a flop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= PS_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_next;
                    r_in_ready <= (w_state_next != PS_TWO);
                end
            end

            always_comb begin
                w_state_next = r_state;
                if (flush) begin
                    w_state_next = PS_EMPTY;
                end else begin
                    case (r_state)
                        PS_EMPTY: if (w_accept) w_state_next = PS_ONE;
                        PS_ONE: begin
                            if (w_accept && !w_fire)      w_state_next = PS_TWO;
                            else if (!w_accept && w_fire) w_state_next = PS_EMPTY;
                        end
                        PS_TWO:   if (w_fire) w_state_next = PS_ONE;
                        default:  w_state_next = PS_EMPTY;
                    endcase
                end
            end

            always_comb begin
                w_main_en       = 1'b0;
                w_main_sel_skid = 1'b0;
                w_skid_en       = 1'b0;
                w_skid_clr      = flush;
                w_main_ctrl_clr = (w_state_next == PS_EMPTY);
                if (!flush) begin
                    case (r_state)
                        PS_EMPTY: w_main_en = w_accept;
                        PS_ONE: begin
                            w_main_en = w_accept & w_fire;
                            w_skid_en = w_accept & ~w_fire;
                        end
                        PS_TWO: begin
                            w_main_en       = w_fire;
                            w_main_sel_skid = 1'b1;
                            w_skid_clr      = w_fire;
                        end
                        default: ;
                    endcase
                end
            end

            pipe_en_reg #(.W(DATA_W)) u_skid_data (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_skid_en),
                .clr   (w_skid_clr),
                .d     (in_data),
                .q     (r_skid_data)
            );

            pipe_en_reg #(.W(CTRL_W)) u_skid_ctrl (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_skid_en),
                .clr   (w_skid_clr),
                .d     (in_ctrl),
                .q     (r_skid_ctrl)
            );

            assign w_main_data_d = w_main_sel_skid ? r_skid_data : in_data;
            assign w_main_ctrl_d = w_main_sel_skid ? r_skid_ctrl : in_ctrl;
            assign in_ready      = r_in_ready;
            assign out_valid     = (r_state != PS_EMPTY);
            assign occupancy     = r_state;
        end else begin : g_noskid
            logic r_valid;
            logic w_valid_next;
            logic w_in_ready;
            logic w_accept;
            logic w_fire;

            assign w_in_ready = ~r_valid | out_ready;
            assign w_accept   = in_valid & w_in_ready & ~flush;
            assign w_fire     = r_valid & out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_valid_next;
                end
            end

            always_comb begin
                w_valid_next = r_valid;
                if (flush)       w_valid_next = 1'b0;
                else if (w_accept) w_valid_next = 1'b1;
                else if (w_fire)   w_valid_next = 1'b0;
            end

            assign w_main_en       = w_accept;
            assign w_main_ctrl_clr = ~w_valid_next;
            assign w_main_data_d   = in_data;
            assign w_main_ctrl_d   = in_ctrl;
            assign in_ready        = w_in_ready;
            assign out_valid       = r_valid;
            assign occupancy       = {1'b0, r_valid};
        end
    endgenerate

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_skid: queue-model bench for SKID=1 and SKID=0 instances    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [7:0]  a_out_ctrl, b_out_ctrl;
    logic [1:0]  a_occ, b_occ;

    int n_vec  = 0;
    int n_fail = 0;

    ent_t        qa[$];
    ent_t        qb[$];
    logic [31:0] la = '0;
    logic [31:0] lb = '0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .occupancy(a_occ)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .occupancy(b_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: each stage is a FIFO of held entries, capacity 2 (skid) or 1 (plain)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete(); qb.delete();
            la = '0; lb = '0;
        end else begin
            bit acc_a, fire_a, acc_b, fire_b;
            acc_a  = in_valid && (qa.size() < 2) && !flush;
            fire_a = (qa.size() > 0) && out_ready;
            acc_b  = in_valid && ((qb.size() == 0) || out_ready) && !flush;
            fire_b = (qb.size() > 0) && out_ready;
            if (flush) begin
                qa.delete(); qb.delete();
            end else begin
                if (fire_a) void'(qa.pop_front());
                if (acc_a)  qa.push_back('{in_data, in_ctrl});
                if (fire_b) void'(qb.pop_front());
                if (acc_b)  qb.push_back('{in_data, in_ctrl});
            end
            if (qa.size() > 0) la = qa[0].d;
            if (qb.size() > 0) lb = qb[0].d;
        end
    end

    always @(negedge clk) begin
        chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, qa.size() > 0});
        chk("a_out_ctrl", {24'd0, a_out_ctrl}, (qa.size() > 0) ? {24'd0, qa[0].c} : 32'd0);
        chk("a_out_data", a_out_data, (qa.size() > 0) ? qa[0].d : la);
        chk("a_occupancy", {30'd0, a_occ}, qa.size());
        chk("a_in_ready", {31'd0, a_in_ready}, {31'd0, qa.size() < 2});
        chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, qb.size() > 0});
        chk("b_out_ctrl", {24'd0, b_out_ctrl}, (qb.size() > 0) ? {24'd0, qb[0].c} : 32'd0);
        chk("b_out_data", b_out_data, (qb.size() > 0) ? qb[0].d : lb);
        chk("b_occupancy", {30'd0, b_occ}, qb.size());
        chk("b_in_ready", {31'd0, b_in_ready}, {31'd0, (qb.size() == 0) || out_ready});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c);
        in_valid = v; in_data = d; in_ctrl = c;
    endtask

    initial begin
        // Reset with a valid entry presented
        drive(1'b1, 32'hDEADBEEF, 8'hFF);
        repeat (3) step();
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_ctrl", {24'd0, a_out_ctrl}, 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_occupancy", {30'd0, a_occ}, 32'd0);
        drive(1'b0, 32'd0, 8'd0);
        rst_n = 1'b1;
        step();

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, i, (i == 3) ? 8'hFF : 8'h11);
            step();
            chk("stream_data", a_out_data, i);
            chk("stream_in_ready", {31'd0, a_in_ready}, 32'd1);
            chk("stream_occ", {30'd0, a_occ}, 32'd1);
        end

        // One-cycle bubble
        drive(1'b0, 32'h0, 8'hFF);
        step();
        chk("bubble_valid", {31'd0, a_out_valid}, 32'd0);
        chk("bubble_ctrl", {24'd0, a_out_ctrl}, 32'd0);
        chk("bubble_data_hold", a_out_data, 32'd3);
        drive(1'b1, 32'd4, 8'hFF);
        step();
        chk("after_bubble_ctrl", {24'd0, a_out_ctrl}, 32'hFF);
        drive(1'b0, 32'd0, 8'd0);
        step();

        // Stall fills the skid
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 8'h10);
        step();
        drive(1'b1, 32'h20, 8'h20);
        step();
        chk("stall_occ", {30'd0, a_occ}, 32'd2);
        chk("stall_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("stall_data", a_out_data, 32'h10);
        drive(1'b0, 32'd0, 8'd0);
        step();
        chk("stall_hold", a_out_data, 32'h10);
        out_ready = 1'b1;
        step();
        chk("release_data", a_out_data, 32'h20);
        chk("release_in_ready", {31'd0, a_in_ready}, 32'd1);
        step();

        // Flush in TWO with a simultaneous valid entry
        out_ready = 1'b0;
        drive(1'b1, 32'h21, 8'h21);
        step();
        drive(1'b1, 32'h22, 8'h22);
        step();
        chk("pre_flush_occ", {30'd0, a_occ}, 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'h30, 8'h30);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 8'd0);
        out_ready = 1'b1;
        chk("flush_valid", {31'd0, a_out_valid}, 32'd0);
        chk("flush_ctrl", {24'd0, a_out_ctrl}, 32'd0);
        chk("flush_occ", {30'd0, a_occ}, 32'd0);
        chk("flush_in_ready", {31'd0, a_in_ready}, 32'd1);
        step();
        chk("flush_c_dropped", {31'd0, a_out_valid}, 32'd0);

        // Plain register: combinational in_ready and one-edge swap
        out_ready = 1'b0;
        drive(1'b1, 32'h40, 8'h40);
        step();
        chk("b_stall_in_ready", {31'd0, b_in_ready}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h41, 8'h41);
        #1;
        chk("b_release_in_ready", {31'd0, b_in_ready}, 32'd1);
        step();
        chk("b_swap_data", b_out_data, 32'h41);
        chk("b_swap_valid", {31'd0, b_out_valid}, 32'd1);

        // Asynchronous reset mid-transfer
        out_ready = 1'b0;
        drive(1'b1, 32'h50, 8'h50);
        step();
        drive(1'b1, 32'h51, 8'h51);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("async_rst_occ", {30'd0, a_occ}, 32'd0);
        chk("async_rst_data", a_out_data, 32'd0);
        chk("async_rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        drive(1'b0, 32'd0, 8'd0);
        step();
        rst_n = 1'b1;
        step();

        // Random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, 8'($urandom));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 32'd0, 8'd0);
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_skid
`default_nettype wire
